seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000: clk cycles per digit slot; legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 value  input  32  eight hex nibbles; nibble i (bits 4i+3..4i) drives digit i.
REQ-005 load  input  1  single-cycle strobe; captures value into the shadow register.
REQ-006 blank_mask  input  8  bit i = 1 forces digit i dark.
REQ-007 lz_en  input  1  1 = suppress leading zero digits.
REQ-008 seg  output  7  segments a..g, bit 6 = a, bit 0 = g, active-high (1 = lit).
REQ-009 an  output  8  digit selects, active-low, at most one bit low at any time.
REQ-010 pending  output  1  shadow holds a value not yet shown.
REQ-011 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 Prescaler counts 0..CLK_DIV-1; tick asserted in the cycle where count = CLK_DIV-1; count then returns to 0.
REQ-013 3-bit digit index advances by 1 on each tick and wraps 7 -> 0.
REQ-014 Frame boundary is the tick on which index wraps 7 -> 0; frame_done pulses high that cycle only.
REQ-015 load: shadow <= value, pending <= 1, on the cycle after the strobe; back-to-back loads keep only the last value.
REQ-016 At a frame boundary with pending = 1: display register <= shadow, pending <= 0.
REQ-017 load coinciding with a frame boundary: the boundary transfers the shadow as it stood before that cycle; the new value goes to shadow and pending stays 1.
REQ-018 Display register changes only at frame boundaries; no digit within a frame shows mixed old/new values.
REQ-019 Nibble to segment map: 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1111011 A=1110111 b=0011111 C=1001110 d=0111101 E=1001111 F=1000111.
REQ-020 Digit i is dark when blank_mask[i] = 1, or when lz_en = 1, i > 0, and nibbles i..7 of the display register are all zero.
REQ-021 Digit 0 is never suppressed by lz_en; blank_mask[0] still darkens it.
REQ-022 Dark digit: an = 8'hFF and seg = 7'b0000000 for that slot.
REQ-023 Lit digit: an has only bit index low; seg is the mapped pattern of that nibble.
REQ-024 seg and an are registered and reflect the index, display register, blank_mask and lz_en from the previous cycle (1-cycle latency).
REQ-025 blank_mask and lz_en are sampled live every cycle and are not shadowed.

Reset
REQ-026 While rst = 1: prescaler = 0, index = 0, display register = 0, shadow = 0, pending = 0, frame_done = 0, an = 8'hFF, seg = 0.
REQ-027 rst overrides load, tick and the frame-boundary transfer in the same cycle; a load during rst is discarded.
REQ-028 First cycle after rst falls: an = 8'hFE, seg = 1111110 (digit 0 showing 0, lz_en and blank_mask permitting).

Verification (CLK_DIV = 4)
REQ-029 Reset release, value never loaded -> an cycles FE, FD, FB ... 7F, changing every 4 cycles; seg = 1111110 on each slot; frame_done pulses every 32 cycles.
REQ-030 load value = 32'h89ABCDEF mid-frame -> pending = 1 until the next boundary; from then on digit 0 shows 1000111 (F), digit 7 shows 1111111 (8); pending = 0.
REQ-031 Two loads, 32'h11111111 then 32'h22222222, before a boundary -> only 2 (1101101) is displayed; 1 never appears.
REQ-032 load 32'h00000005 exactly on the boundary cycle, with shadow = 32'h00000003 and pending = 1 -> 3 is shown this frame, 5 next frame; pending stays 1 across the boundary.
REQ-033 lz_en = 1, display = 32'h00000A00 -> digits 0..2 lit (0, 0, A = 1110111); digits 3..7 an = FF, seg = 0; display = 0 -> only digit 0 lit.
REQ-034 rst asserted mid-frame with pending = 1 -> all state cleared the next cycle; shadow value is not transferred; an = FF during rst.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scanner with a frame-synchronous shadow
// register, per-digit blanking and optional leading-zero suppression.
module seg_scan_ctrl #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        load,
  input  logic [7:0]  blank_mask,
  input  logic        lz_en,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam logic [19:0] DIV_LAST = 20'(CLK_DIV - 1);

  logic [19:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] disp_q, disp_d;
  logic        pending_q, pending_d;
  logic [6:0]  seg_q, seg_d;
  logic [7:0]  an_q, an_d;

  logic        tick;
  logic        boundary;
  logic [7:0]  upper_nz;
  logic [3:0]  nib;
  logic        dark;

  assign tick     = (presc_q == DIV_LAST);
  assign boundary = tick && (idx_q == 3'd7);

  // upper_nz[i] is set when any of nibbles i..7 is non-zero
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_upper
      assign upper_nz[gi] = |disp_q[31:4*gi];
    end
  endgenerate

  assign nib  = disp_q[{idx_q, 2'b00} +: 4];
  assign dark = blank_mask[idx_q] | (lz_en & (idx_q != 3'd0) & ~upper_nz[idx_q]);

  always_comb begin
    presc_d   = tick ? 20'd0 : presc_q + 20'd1;
    idx_d     = tick ? idx_q + 3'd1 : idx_q;
    shadow_d  = load ? value : shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    // The boundary consumes the shadow as it stood before a coincident load
    if (boundary && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    seg_d = 7'b0000000;
    case (nib)
      4'h0: seg_d = 7'b1111110;
      4'h1: seg_d = 7'b0110000;
      4'h2: seg_d = 7'b1101101;
      4'h3: seg_d = 7'b1111001;
      4'h4: seg_d = 7'b0110011;
      4'h5: seg_d = 7'b1011011;
      4'h6: seg_d = 7'b1011111;
      4'h7: seg_d = 7'b1110000;
      4'h8: seg_d = 7'b1111111;
      4'h9: seg_d = 7'b1111011;
      4'hA: seg_d = 7'b1110111;
      4'hB: seg_d = 7'b0011111;
      4'hC: seg_d = 7'b1001110;
      4'hD: seg_d = 7'b0111101;
      4'hE: seg_d = 7'b1001111;
      4'hF: seg_d = 7'b1000111;
      default: seg_d = 7'b0000000;
    endcase
    an_d = ~(8'h01 << idx_q);
    if (dark) begin
      seg_d = 7'b0000000;
      an_d  = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      seg_q     <= 7'b0000000;
      an_q      <= 8'hFF;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_done = boundary & ~rst;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl at CLK_DIV = 4: stimulus queues expected
// slot/frame observations by cycle number, a monitor pops and compares them.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic        load;
  logic [7:0]  blank_mask;
  logic        lz_en;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        pending;
  logic        frame_done;

  seg_scan_ctrl #(.CLK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .blank_mask (blank_mask),
    .lz_en      (lz_en),
    .seg        (seg),
    .an         (an),
    .pending    (pending),
    .frame_done (frame_done)
  );

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SA = 7'b1110111;
  localparam logic [6:0] SB = 7'b0011111;
  localparam logic [6:0] SC = 7'b1001110;
  localparam logic [6:0] SD = 7'b0111101;
  localparam logic [6:0] SE = 7'b1001111;
  localparam logic [6:0] SF = 7'b1000111;

  typedef struct {
    int         cyc;
    bit         is_fd;
    logic [7:0] an;
    logic [6:0] seg;
    logic       pend;
    logic       fd;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   base_r = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input bit is_fd, input logic [7:0] a,
                      input logic [6:0] s, input logic p, input logic f, input string nm);
    exp_t e;
    e.cyc = c; e.is_fd = is_fd; e.an = a; e.seg = s; e.pend = p; e.fd = f; e.nm = nm;
    sb.push_back(e);
  endtask

  // segs packs digit 7 in the top 7 bits down to digit 0 in the bottom 7 bits
  task automatic push_frame(input int m, input logic [55:0] segs, input logic [7:0] dark,
                            input logic [7:0] pend, input int ndig);
    int         b;
    logic [7:0] a;
    logic [6:0] s;
    b = base_r + 32 * m;
    for (int d = 0; d < ndig; d++) begin
      a = 8'hFF;
      s = 7'b0000000;
      if (!dark[d]) begin
        a[d] = 1'b0;
        s = segs[7*d +: 7];
      end
      push(b + 4*d + 2, 1'b0, a, s, pend[d], 1'b0, $sformatf("f%0d_d%0d", m, d));
    end
    if (ndig == 8) begin
      push(b + 30, 1'b1, 8'h00, 7'h00, 1'b0, 1'b0, $sformatf("f%0d_fd_low", m));
      push(b + 31, 1'b1, 8'h00, 7'h00, 1'b0, 1'b1, $sformatf("f%0d_fd_pulse", m));
    end
  endtask

  task automatic wait_rel(input int r);
    while (cyc < base_r + r) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input int r, input logic [31:0] v);
    wait_rel(r - 1);
    value = v;
    load  = 1'b1;
    wait_rel(r);
    load  = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (e.cyc < cyc) begin
          n_fail++;
          $display("FAIL %s: not observed at cycle %0d, now at cycle %0d", e.nm, e.cyc, cyc);
        end else if (e.is_fd) begin
          if (frame_done !== e.fd) begin
            n_fail++;
            $display("FAIL %s: frame_done=%b required %b", e.nm, frame_done, e.fd);
          end else begin
            $display("ok   %s: frame_done=%b", e.nm, frame_done);
          end
        end else if (an !== e.an || seg !== e.seg || pending !== e.pend) begin
          n_fail++;
          $display("FAIL %s: an=%h seg=%b pending=%b required an=%h seg=%b pending=%b",
                   e.nm, an, seg, pending, e.an, e.seg, e.pend);
        end else begin
          $display("ok   %s: an=%h seg=%b pending=%b", e.nm, an, seg, pending);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst        = 1'b1;
    load       = 1'b1;
    value      = 32'hDEADBEEF;
    blank_mask = 8'h00;
    lz_en      = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // load held high during reset must be discarded
    push(cyc, 1'b0, 8'hFF, 7'h00, 1'b0, 1'b0, "reset_state");
    push(cyc, 1'b1, 8'h00, 7'h00, 1'b0, 1'b0, "reset_fd");
    @(posedge clk);
    #1;
    base_r = cyc;
    rst    = 1'b0;
    load   = 1'b0;
    value  = 32'h0;

    push_frame(0, {8{S0}}, 8'h00, 8'h00, 8);
    wait_rel(32);
    push_frame(1, {8{S0}}, 8'h00, 8'hFC, 8);
    strobe(41, 32'h89ABCDEF);

    wait_rel(64);
    push_frame(2, {S8, S9, SA, SB, SC, SD, SE, SF}, 8'h00, 8'hFC, 8);
    wait_rel(71);
    value = 32'h11111111;
    load  = 1'b1;
    wait_rel(72);
    value = 32'h22222222;
    wait_rel(73);
    load  = 1'b0;

    wait_rel(96);
    push_frame(3, {8{S2}}, 8'h00, 8'hFE, 8);
    strobe(100, 32'h00000003);
    wait_rel(127);
    value = 32'h00000005;
    load  = 1'b1;
    wait_rel(128);
    load  = 1'b0;
    push_frame(4, {{7{S0}}, S3}, 8'h00, 8'hFF, 8);

    wait_rel(160);
    push_frame(5, {{7{S0}}, S5}, 8'h00, 8'hFC, 8);
    strobe(170, 32'h00000A00);

    wait_rel(192);
    lz_en = 1'b1;
    push_frame(6, {{5{S0}}, SA, S0, S0}, 8'hF8, 8'hFC, 8);
    strobe(200, 32'h00000000);

    wait_rel(224);
    push_frame(7, {8{S0}}, 8'hFE, 8'h00, 8);

    wait_rel(256);
    blank_mask = 8'h01;
    push_frame(8, {8{S0}}, 8'hFF, 8'hFE, 8);
    strobe(260, 32'h12345678);

    wait_rel(288);
    lz_en      = 1'b0;
    blank_mask = 8'h00;
    push_frame(9, {{5{S0}}, S6, S7, S8}, 8'h00, 8'h06, 3);
    strobe(292, 32'h87654321);

    wait_rel(298);
    rst = 1'b1;
    push(base_r + 299, 1'b0, 8'hFF, 7'h00, 1'b0, 1'b0, "midframe_rst_a");
    push(base_r + 300, 1'b0, 8'hFF, 7'h00, 1'b0, 1'b0, "midframe_rst_b");
    push(base_r + 300, 1'b1, 8'h00, 7'h00, 1'b0, 1'b0, "midframe_rst_fd");
    wait_rel(302);
    rst    = 1'b0;
    base_r = cyc;
    push(base_r + 1, 1'b0, 8'hFE, S0, 1'b0, 1'b0, "post_rst_first");
    push_frame(0, {8{S0}}, 8'h00, 8'h00, 8);
    wait_rel(32);
    push_frame(1, {8{S0}}, 8'h00, 8'h00, 8);
    wait_rel(66);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
